rom_arbiter: RTL and testbench

ROM_ARBITER -- requirements
Module: rom_arbiter

---
 rtl/rom_arb_pkg.sv | 20 ++
 rtl/rom_arb_rr.sv | 21 ++
 rtl/rom_arbiter.sv | 115 +++++++++++
 tb/tb_rom_arbiter.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_arb_pkg.sv
// Shared definitions for the two-port ROM arbiter: FSM state encoding,
// default ROM region, port id type and the address error rule.
package rom_arb_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_WAIT = 2'd1;
    localparam state_t ST_RESP = 2'd2;

    typedef logic port_id_t;

    localparam logic [7:0] ROM_REGION_DEFAULT = 8'h20;

    // Out-of-region or non-word-aligned reads are answered with an error.
    function automatic logic addr_is_err(input logic [31:0] addr, input logic [7:0] region);
        return (addr[31:24] != region) || (addr[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/rom_arb_rr.sv
// Two-way round-robin picker: a lone valid wins, on contention the port
// that was not served last wins. Grant is one-hot (or zero when idle).
module rom_arb_rr
    import rom_arb_pkg::*;
(
    input  logic       valid0,
    input  logic       valid1,
    input  port_id_t   last_grant,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        if (valid0 && valid1) begin
            grant = (last_grant == 1'b1) ? 2'b01 : 2'b10;
        end else begin
            grant = {valid1, valid0};
        end
    end

endmodule

// File: rtl/rom_arbiter.sv
// Arbitrates two requesters onto one fixed-latency ROM controller; one
// access in flight at a time, response returned as a one-cycle pulse.
module rom_arbiter
    import rom_arb_pkg::*;
#(
    parameter int         LATENCY    = 1,
    parameter logic [7:0] ROM_REGION = ROM_REGION_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    input  logic [31:0] req0_addr,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [31:0] req1_addr,
    output logic        req1_ready,
    output logic        rsp0_valid,
    output logic [31:0] rsp0_data,
    output logic        rsp0_err,
    output logic        rsp1_valid,
    output logic [31:0] rsp1_data,
    output logic        rsp1_err,
    output logic [31:0] rom_addr,
    input  logic [31:0] rom_data
);

    localparam logic [2:0] LAT_LAST = 3'(LATENCY - 1);

    state_t     state;
    port_id_t   last_grant;
    port_id_t   cur_port;
    logic       cur_err;
    logic [2:0] lat_cnt;
    logic [1:0] grant;
    logic       accept;
    logic       lat_done;
    logic [31:0] accept_addr;

    rom_arb_rr u_rr (
        .valid0     (req0_valid),
        .valid1     (req1_valid),
        .last_grant (last_grant),
        .grant      (grant)
    );

    assign req0_ready  = (state == ST_IDLE) && grant[0];
    assign req1_ready  = (state == ST_IDLE) && grant[1];
    assign accept      = req0_ready || req1_ready;
    assign accept_addr = grant[1] ? req1_addr : req0_addr;
    assign lat_done    = (lat_cnt == LAT_LAST);

    // rom_addr doubles as the latched request address and holds in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            last_grant <= 1'b1;
            cur_port   <= 1'b0;
            cur_err    <= 1'b0;
            lat_cnt    <= 3'd0;
            rom_addr   <= 32'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state      <= ST_WAIT;
                        rom_addr   <= accept_addr;
                        cur_port   <= grant[1];
                        cur_err    <= addr_is_err(accept_addr, ROM_REGION);
                        last_grant <= grant[1];
                        lat_cnt    <= 3'd0;
                    end
                end
                ST_WAIT: begin
                    if (lat_done) begin
                        state   <= ST_RESP;
                        lat_cnt <= 3'd0;
                    end else begin
                        lat_cnt <= lat_cnt + 3'd1;
                    end
                end
                ST_RESP: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Response registers load on the WAIT->RESP edge so the pulse lands in RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp0_valid <= 1'b0;
            rsp0_err   <= 1'b0;
            rsp0_data  <= 32'd0;
            rsp1_valid <= 1'b0;
            rsp1_err   <= 1'b0;
            rsp1_data  <= 32'd0;
        end else begin
            rsp0_valid <= 1'b0;
            rsp0_err   <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp1_err   <= 1'b0;
            if (state == ST_WAIT && lat_done) begin
                if (cur_port) begin
                    rsp1_valid <= 1'b1;
                    rsp1_err   <= cur_err;
                    rsp1_data  <= cur_err ? 32'd0 : rom_data;
                end else begin
                    rsp0_valid <= 1'b1;
                    rsp0_err   <= cur_err;
                    rsp0_data  <= cur_err ? 32'd0 : rom_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_rom_arbiter.sv
// Self-checking bench: LATENCY=1 and LATENCY=3 instances share the request
// inputs, each tracked by its own cycle-level model plus directed literals.
module tb_rom_arbiter;

    localparam logic [31:0] ROM_KEY = 32'h5A5A_5A5A;

    logic        clk;
    logic        rst_n;
    logic        req0_valid;
    logic [31:0] req0_addr;
    logic        req1_valid;
    logic [31:0] req1_addr;
    int          cyc;
    int          total;
    int          bad;

    logic        a_ready0, a_ready1, a_rsp0_valid, a_rsp1_valid, a_rsp0_err, a_rsp1_err;
    logic [31:0] a_rsp0_data, a_rsp1_data, a_rom_addr, a_rom_data;
    logic        b_ready0, b_ready1, b_rsp0_valid, b_rsp1_valid, b_rsp0_err, b_rsp1_err;
    logic [31:0] b_rsp0_data, b_rsp1_data, b_rom_addr, b_rom_data;

    // ROM contents depend on address and on the cycle, so capture timing shows up in the data.
    assign a_rom_data = a_rom_addr ^ ROM_KEY ^ 32'(cyc);
    assign b_rom_data = b_rom_addr ^ ROM_KEY ^ 32'(cyc);

    rom_arbiter #(.LATENCY(1), .ROM_REGION(8'h20)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_ready(a_ready0),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_ready(a_ready1),
        .rsp0_valid(a_rsp0_valid), .rsp0_data(a_rsp0_data), .rsp0_err(a_rsp0_err),
        .rsp1_valid(a_rsp1_valid), .rsp1_data(a_rsp1_data), .rsp1_err(a_rsp1_err),
        .rom_addr(a_rom_addr), .rom_data(a_rom_data)
    );

    rom_arbiter #(.LATENCY(3), .ROM_REGION(8'h20)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_ready(b_ready0),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_ready(b_ready1),
        .rsp0_valid(b_rsp0_valid), .rsp0_data(b_rsp0_data), .rsp0_err(b_rsp0_err),
        .rsp1_valid(b_rsp1_valid), .rsp1_data(b_rsp1_data), .rsp1_err(b_rsp1_err),
        .rom_addr(b_rom_addr), .rom_data(b_rom_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic applyStimulus(input logic v0, input logic [31:0] a0,
                                 input logic v1, input logic [31:0] a1);
        @(posedge clk);
        #1;
        req0_valid = v0;
        req0_addr  = a0;
        req1_valid = v1;
        req1_addr  = a1;
    endtask

    task automatic idleCycles(input int n);
        applyStimulus(1'b0, 32'd0, 1'b0, 32'd0);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Transaction-level model, one slot per instance (0: LATENCY=1, 1: LATENCY=3).
    bit          m_pending [2];
    int          m_rsp_cyc [2];
    int          m_free_at [2];
    bit          m_port    [2];
    bit          m_err     [2];
    logic [31:0] m_data    [2];
    bit          m_last    [2];
    logic [31:0] m_rom_addr[2];
    logic [31:0] m_rdata0  [2];
    logic [31:0] m_rdata1  [2];

    task automatic modelStep(input int i, input int lat,
                             input logic rdy0, input logic rdy1,
                             input logic rv0, input logic rv1,
                             input logic re0, input logic re1,
                             input logic [31:0] rd0, input logic [31:0] rd1,
                             input logic [31:0] raddr);
        string tag;
        bit ev0, ev1, ee0, ee1, g0, g1;
        logic [31:0] addr;
        tag = (i == 0) ? "L1" : "L3";
        if (!rst_n) begin
            m_pending[i]  = 0;
            m_free_at[i]  = 0;
            m_last[i]     = 1;
            m_rom_addr[i] = 32'd0;
            m_rdata0[i]   = 32'd0;
            m_rdata1[i]   = 32'd0;
            checkOutput({tag, "_rst_rsp0_valid"}, 32'(rv0), 32'd0);
            checkOutput({tag, "_rst_rsp1_valid"}, 32'(rv1), 32'd0);
            checkOutput({tag, "_rst_rsp0_err"}, 32'(re0), 32'd0);
            checkOutput({tag, "_rst_rsp1_err"}, 32'(re1), 32'd0);
            checkOutput({tag, "_rst_rsp0_data"}, rd0, 32'd0);
            checkOutput({tag, "_rst_rsp1_data"}, rd1, 32'd0);
            checkOutput({tag, "_rst_rom_addr"}, raddr, 32'd0);
            return;
        end
        ev0 = 0; ev1 = 0; ee0 = 0; ee1 = 0;
        if (m_pending[i] && cyc == m_rsp_cyc[i]) begin
            if (m_port[i]) begin
                ev1 = 1; ee1 = m_err[i]; m_rdata1[i] = m_data[i];
            end else begin
                ev0 = 1; ee0 = m_err[i]; m_rdata0[i] = m_data[i];
            end
            m_pending[i] = 0;
        end
        g0 = 0; g1 = 0;
        if (cyc >= m_free_at[i]) begin
            if (req0_valid && req1_valid) begin
                g0 = m_last[i];
                g1 = !m_last[i];
            end else begin
                g0 = req0_valid;
                g1 = req1_valid;
            end
        end
        checkOutput({tag, "_ready0"}, 32'(rdy0), 32'(g0));
        checkOutput({tag, "_ready1"}, 32'(rdy1), 32'(g1));
        checkOutput({tag, "_ready_excl"}, 32'(rdy0 & rdy1), 32'd0);
        checkOutput({tag, "_rsp0_valid"}, 32'(rv0), 32'(ev0));
        checkOutput({tag, "_rsp1_valid"}, 32'(rv1), 32'(ev1));
        checkOutput({tag, "_rsp0_err"}, 32'(re0), 32'(ee0));
        checkOutput({tag, "_rsp1_err"}, 32'(re1), 32'(ee1));
        checkOutput({tag, "_rsp0_data"}, rd0, m_rdata0[i]);
        checkOutput({tag, "_rsp1_data"}, rd1, m_rdata1[i]);
        checkOutput({tag, "_rom_addr"}, raddr, m_rom_addr[i]);
        if (g0 || g1) begin
            addr          = g1 ? req1_addr : req0_addr;
            m_err[i]      = (addr[31:24] != 8'h20) || (addr[1:0] != 2'b00);
            m_data[i]     = m_err[i] ? 32'd0 : (addr ^ ROM_KEY ^ 32'(cyc + lat));
            m_port[i]     = g1;
            m_last[i]     = g1;
            m_rom_addr[i] = addr;
            m_rsp_cyc[i]  = cyc + lat + 1;
            m_free_at[i]  = cyc + lat + 2;
            m_pending[i]  = 1;
        end
    endtask

    always @(negedge clk) begin
        modelStep(0, 1, a_ready0, a_ready1, a_rsp0_valid, a_rsp1_valid, a_rsp0_err, a_rsp1_err,
                  a_rsp0_data, a_rsp1_data, a_rom_addr);
        modelStep(1, 3, b_ready0, b_ready1, b_rsp0_valid, b_rsp1_valid, b_rsp0_err, b_rsp1_err,
                  b_rsp0_data, b_rsp1_data, b_rom_addr);
    end

    int t0;
    int gport[$];
    int gcyc[$];

    initial begin
        total = 0;
        bad = 0;
        rst_n = 1'b0;
        req0_valid = 1'b0;
        req0_addr = 32'd0;
        req1_valid = 1'b0;
        req1_addr = 32'd0;
        repeat (3) @(negedge clk);
        checkOutput("init_rom_addr", a_rom_addr, 32'd0);
        checkOutput("init_rsp0_data", b_rsp0_data, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        idleCycles(2);

        $display("[TB] single aligned read on port 0");
        applyStimulus(1'b1, 32'h2000_0004, 1'b0, 32'd0);
        @(negedge clk); t0 = cyc;
        checkOutput("A_ready0", 32'(a_ready0), 32'd1);
        checkOutput("A_ready1", 32'(a_ready1), 32'd0);
        applyStimulus(1'b0, 32'h2000_0004, 1'b0, 32'd0);
        @(negedge clk);
        checkOutput("A_rom_addr", a_rom_addr, 32'h2000_0004);
        @(negedge clk);
        checkOutput("A_rsp0_valid", 32'(a_rsp0_valid), 32'd1);
        checkOutput("A_rsp0_data", a_rsp0_data, 32'h2000_0004 ^ ROM_KEY ^ 32'(t0 + 1));
        checkOutput("A_rsp0_err", 32'(a_rsp0_err), 32'd0);
        idleCycles(6);

        $display("[TB] contention held through reset exit");
        rst_n = 1'b0;
        req0_valid = 1'b1; req0_addr = 32'h2000_0010;
        req1_valid = 1'b1; req1_addr = 32'h2000_0020;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk); t0 = cyc;
        for (int k = 0; k < 12; k++) begin
            if (k > 0) @(negedge clk);
            if (a_ready0) begin gport.push_back(0); gcyc.push_back(cyc); end
            if (a_ready1) begin gport.push_back(1); gcyc.push_back(cyc); end
        end
        if (gport.size() < 4) begin
            total++; bad++;
            $display("[TB] FAIL C_grant_count: got %0d expected 4", gport.size());
        end else begin
            checkOutput("C_first_accept", 32'(gcyc[0]), 32'(t0));
            for (int k = 0; k < 4; k++) begin
                checkOutput("C_grant_port", 32'(gport[k]), 32'(k % 2));
                if (k > 0) checkOutput("C_grant_gap", 32'(gcyc[k] - gcyc[k-1]), 32'd3);
            end
        end
        idleCycles(8);

        $display("[TB] error responses on port 1");
        applyStimulus(1'b0, 32'd0, 1'b1, 32'h1000_0000);
        @(negedge clk); t0 = cyc;
        applyStimulus(1'b0, 32'd0, 1'b0, 32'd0);
        @(negedge clk);
        @(negedge clk);
        checkOutput("B_region_valid", 32'(a_rsp1_valid), 32'd1);
        checkOutput("B_region_data", a_rsp1_data, 32'd0);
        checkOutput("B_region_err", 32'(a_rsp1_err), 32'd1);
        idleCycles(6);
        applyStimulus(1'b0, 32'd0, 1'b1, 32'h2000_0002);
        @(negedge clk);
        applyStimulus(1'b0, 32'd0, 1'b0, 32'd0);
        @(negedge clk);
        @(negedge clk);
        checkOutput("B_align_valid", 32'(a_rsp1_valid), 32'd1);
        checkOutput("B_align_data", a_rsp1_data, 32'd0);
        checkOutput("B_align_err", 32'(a_rsp1_err), 32'd1);
        idleCycles(6);

        $display("[TB] reset during WAIT");
        applyStimulus(1'b1, 32'h2000_0008, 1'b0, 32'd0);
        @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        req0_valid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            checkOutput("D_rst_rsp0_valid", 32'(b_rsp0_valid | a_rsp0_valid), 32'd0);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        req0_valid = 1'b1; req0_addr = 32'h2000_000C;
        @(negedge clk); t0 = cyc;
        checkOutput("D_ready0", 32'(a_ready0), 32'd1);
        applyStimulus(1'b0, 32'd0, 1'b0, 32'd0);
        @(negedge clk);
        @(negedge clk);
        checkOutput("D_rsp0_valid", 32'(a_rsp0_valid), 32'd1);
        checkOutput("D_rsp0_data", a_rsp0_data, 32'h2000_000C ^ ROM_KEY ^ 32'(t0 + 1));
        idleCycles(8);

        $display("[TB] LATENCY=3 with address change after accept");
        applyStimulus(1'b1, 32'h2000_0040, 1'b0, 32'd0);
        @(negedge clk); t0 = cyc;
        checkOutput("E_ready0", 32'(b_ready0), 32'd1);
        applyStimulus(1'b1, 32'h2000_0080, 1'b0, 32'd0);
        @(negedge clk);
        checkOutput("E_rom_addr1", b_rom_addr, 32'h2000_0040);
        applyStimulus(1'b0, 32'h2000_00C0, 1'b0, 32'd0);
        @(negedge clk);
        checkOutput("E_rom_addr2", b_rom_addr, 32'h2000_0040);
        @(negedge clk);
        checkOutput("E_rom_addr3", b_rom_addr, 32'h2000_0040);
        checkOutput("E_early_valid", 32'(b_rsp0_valid), 32'd0);
        @(negedge clk);
        checkOutput("E_rsp0_valid", 32'(b_rsp0_valid), 32'd1);
        checkOutput("E_rsp0_data", b_rsp0_data, 32'h2000_0040 ^ ROM_KEY ^ 32'(t0 + 3));
        idleCycles(6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
